// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed 34-cycle start-to-done latency with synchronous kill.
module mdu_iter #(
   parameter int XLEN = 32,
   parameter int OP_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [OP_W-1:0] alu_op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int CNT_W = $clog2(XLEN);
   localparam logic [OP_W-1:0] OP_MULU   = OP_W'(5'd9);
   localparam logic [OP_W-1:0] OP_MULHS  = OP_W'(5'd10);
   localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(5'd11);
   localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(5'd12);
   localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(5'd13);
   localparam logic [OP_W-1:0] OP_DIVS   = OP_W'(5'd14);
   localparam logic [OP_W-1:0] OP_REMU   = OP_W'(5'd15);
   localparam logic [OP_W-1:0] OP_REMS   = OP_W'(5'd16);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);
   localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_q;
   logic [OP_W-1:0]     op_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN:0]       rem_q, rem_d;
   logic [XLEN-1:0]     opnd_q, a_q, result_q, result_d;
   logic                is_mul_q, neg_q, rneg_q, div0_q, ovf_q, busy_q, done_q;

   logic                a_sgn_s, b_sgn_s, valid_op_s, is_mul_s, accept_s, ovf_s;
   logic [XLEN-1:0]     a_mag_s, b_mag_s;
   logic [XLEN:0]       mul_sum_s, div_shl_s, div_diff_s;
   logic [2*XLEN-1:0]   prod_s;
   logic [XLEN-1:0]     quo_s, rem_s;

   // Op decode, operand magnitudes and start acceptance
   always_comb begin
      a_sgn_s    = 1'b0;
      b_sgn_s    = 1'b0;
      valid_op_s = 1'b1;
      case (alu_op_i)
         OP_MULU, OP_MULHU, OP_DIVU, OP_REMU: valid_op_s = 1'b1;
         OP_MULHSU:                           a_sgn_s    = 1'b1;
         OP_MULHS, OP_DIVS, OP_REMS: begin
            a_sgn_s = 1'b1;
            b_sgn_s = 1'b1;
         end
         default:                             valid_op_s = 1'b0;
      endcase
      is_mul_s = (alu_op_i >= OP_MULU) && (alu_op_i <= OP_MULHU);
      a_mag_s  = (a_sgn_s && a_i[XLEN-1]) ? (~a_i + 1'b1) : a_i;
      b_mag_s  = (b_sgn_s && b_i[XLEN-1]) ? (~b_i + 1'b1) : b_i;
      ovf_s    = ((alu_op_i == OP_DIVS) || (alu_op_i == OP_REMS)) &&
                 (a_i == INT_MIN) && (b_i == ALL_ONES);
      accept_s = start_i && !kill_i && valid_op_s &&
                 ((state_q == IDLE) || (state_q == DONE));
   end

   // One iteration: shift-add for multiply, restore-or-subtract for divide
   always_comb begin
      mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
      div_shl_s  = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
      div_diff_s = div_shl_s - {1'b0, opnd_q};
      if (is_mul_q) begin
         acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
         rem_d = rem_q;
      end else begin
         acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff_s[XLEN]};
         rem_d = div_diff_s[XLEN] ? div_shl_s : div_diff_s;
      end
   end

   // Sign correction and divide special-case override
   always_comb begin
      prod_s = neg_q  ? (~acc_q + 1'b1) : acc_q;
      quo_s  = neg_q  ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem_s  = rneg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
      case (op_q)
         OP_MULU:                      result_d = prod_s[XLEN-1:0];
         OP_MULHS, OP_MULHSU, OP_MULHU: result_d = prod_s[2*XLEN-1:XLEN];
         OP_DIVU, OP_DIVS: begin
            if (div0_q)     result_d = ALL_ONES;
            else if (ovf_q) result_d = INT_MIN;
            else            result_d = quo_s;
         end
         OP_REMU, OP_REMS: begin
            if (div0_q)     result_d = a_q;
            else if (ovf_q) result_d = {XLEN{1'b0}};
            else            result_d = rem_s;
         end
         default:                      result_d = result_q;
      endcase
   end

   // Control FSM with datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= {OP_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         acc_q    <= {(2*XLEN){1'b0}};
         rem_q    <= {(XLEN+1){1'b0}};
         opnd_q   <= {XLEN{1'b0}};
         a_q      <= {XLEN{1'b0}};
         result_q <= {XLEN{1'b0}};
         is_mul_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (accept_s) begin
         state_q  <= CALC;
         op_q     <= alu_op_i;
         cnt_q    <= {CNT_W{1'b0}};
         acc_q    <= {{XLEN{1'b0}}, (is_mul_s ? b_mag_s : a_mag_s)};
         rem_q    <= {(XLEN+1){1'b0}};
         opnd_q   <= is_mul_s ? a_mag_s : b_mag_s;
         a_q      <= a_i;
         is_mul_q <= is_mul_s;
         neg_q    <= (a_sgn_s && a_i[XLEN-1]) ^ (b_sgn_s && b_i[XLEN-1]);
         rneg_q   <= a_sgn_s && a_i[XLEN-1];
         div0_q   <= (b_i == {XLEN{1'b0}});
         ovf_q    <= ovf_s;
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: done_q <= 1'b0;
            CALC: begin
               if (kill_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  rem_q <= rem_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) state_q <= FIN;
               end
            end
            FIN: begin
               busy_q <= 1'b0;
               if (kill_i) begin
                  state_q <= IDLE;
               end else begin
                  result_q <= result_d;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed cases, handshake/kill/reset corners and
// randomized ops checked against an arithmetic reference model.
module tb_mdu_iter;
   logic        clk = 1'b0;
   logic        rst;
   logic        start_i, kill_i;
   logic [4:0]  alu_op_i;
   logic [31:0] a_i, b_i, result_o;
   logic        busy_o, done_o;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] last_res;

   mdu_iter dut (
      .clk(clk), .rst(rst), .start_i(start_i), .kill_i(kill_i),
      .alu_op_i(alu_op_i), .a_i(a_i), .b_i(b_i),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done_o pulse must match the oldest expected result and cycle
   always @(negedge clk) begin
      if (rst && done_o) begin
         nvec++;
         if (sb.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_done: result_o=%h at cycle %0d, required no done_o", result_o, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (result_o !== mon_e.res || cyc != mon_e.cyc) begin
               nerr++;
               $display("FAIL result: got %h at cycle %0d, expected %h at cycle %0d",
                        result_o, cyc, mon_e.res, mon_e.cyc);
            end
         end
      end
   end

   function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb_v, sp;
      longint unsigned ua, ub, up;
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      ua   = {32'd0, a};
      ub   = {32'd0, b};
      case (op)
         5'd9:  begin up = ua * ub;            return up[31:0];  end
         5'd10: begin sp = sa * sb_v;          return sp[63:32]; end
         5'd11: begin sp = sa * longint'(ub);  return sp[63:32]; end
         5'd12: begin up = ua * ub;            return up[63:32]; end
         5'd13: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         5'd14: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            sp = sa / sb_v;
            return sp[31:0];
         end
         5'd15: return (b == 32'd0) ? a : a % b;
         5'd16: begin
            if (b == 32'd0) return a;
            sp = sa % sb_v;
            return sp[31:0];
         end
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge: drive start for one cycle, then scramble the inputs
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] exp);
      start_i  = 1'b1;
      alu_op_i = op;
      a_i      = a;
      b_i      = b;
      if (push) sb.push_back('{exp, cyc + 34});
      @(negedge clk);
      start_i  = 1'b0;
      alu_op_i = 5'($urandom_range(0, 31));
      a_i      = $urandom;
      b_i      = $urandom;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   logic [4:0]  d_op  [14] = '{5'd9, 5'd10, 5'd12, 5'd11, 5'd14, 5'd16, 5'd13, 5'd15,
                                5'd13, 5'd15, 5'd14, 5'd16, 5'd14, 5'd16};
   logic [31:0] d_a   [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
   logic [31:0] d_b   [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
   logic [31:0] d_exp [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'hFFFF_FFFF,
                                32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
   logic [4:0]  bad_op [5] = '{5'd0, 5'd1, 5'd8, 5'd17, 5'd31};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [4:0]  op;
      logic [31:0] ra, rb, exp;
      int          gap;
      rst = 1'b0; start_i = 1'b0; kill_i = 1'b0;
      alu_op_i = 5'd0; a_i = 32'd0; b_i = 32'd0;
      @(negedge clk);
      chk("reset_busy",   {31'd0, busy_o}, 32'd0);
      chk("reset_done",   {31'd0, done_o}, 32'd0);
      chk("reset_result", result_o,        32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // mulu latency and busy window
      issue(5'd9, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
      for (int t = 1; t <= 35; t++) begin
         chk("busy_window", {31'd0, busy_o}, {31'd0, (t <= 33)});
         @(negedge clk);
      end
      drain();

      for (int i = 0; i < 14; i++) begin
         issue(d_op[i], d_a[i], d_b[i], 1'b1, d_exp[i]);
         drain();
         last_res = d_exp[i];
      end

      // Kill in CALC cycle 10, then restart in cycle 12
      issue(5'd13, 32'd100, 32'd7, 1'b0, 32'd0);
      repeat (9) @(negedge clk);
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      chk("kill_calc_busy",   {31'd0, busy_o}, 32'd0);
      chk("kill_calc_result", result_o,        last_res);
      issue(5'd9, 32'd3, 32'd5, 1'b1, 32'd15);
      drain();
      last_res = 32'd15;

      // Kill in FIN
      issue(5'd12, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'd0);
      repeat (32) @(negedge clk);
      chk("fin_busy", {31'd0, busy_o}, 32'd1);
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("kill_fin_busy",   {31'd0, busy_o}, 32'd0);
      chk("kill_fin_result", result_o,        last_res);

      // Kill together with start in DONE: done still pulses, start ignored
      issue(5'd13, 32'd1000, 32'd10, 1'b1, 32'd100);
      repeat (33) @(negedge clk);
      chk("done_pulse", {31'd0, done_o}, 32'd1);
      kill_i = 1'b1; start_i = 1'b1; alu_op_i = 5'd9; a_i = 32'd2; b_i = 32'd2;
      @(negedge clk);
      kill_i = 1'b0; start_i = 1'b0;
      chk("kill_start_busy", {31'd0, busy_o}, 32'd0);
      repeat (40) @(negedge clk);
      drain();
      chk("kill_done_result", result_o, 32'd100);

      // Start in the DONE cycle chains directly
      issue(5'd15, 32'd1000, 32'd7, 1'b1, 32'd6);
      repeat (33) @(negedge clk);
      issue(5'd14, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2);
      drain();

      // Start while busy is ignored
      issue(5'd9, 32'd6, 32'd7, 1'b1, 32'd42);
      repeat (5) @(negedge clk);
      issue(5'd13, 32'd9, 32'd3, 1'b0, 32'd0);
      drain();
      chk("busy_start_result", result_o, 32'd42);

      // Non-M op codes are ignored
      foreach (bad_op[i]) begin
         issue(bad_op[i], $urandom, $urandom, 1'b0, 32'd0);
         chk("bad_op_busy", {31'd0, busy_o}, 32'd0);
      end
      repeat (40) @(negedge clk);
      chk("bad_op_result", result_o, 32'd42);

      // Randomized ops, sometimes back-to-back or with an ignored busy start
      for (int i = 0; i < 60; i++) begin
         op  = 5'd9 + 5'($urandom_range(0, 7));
         ra  = pick();
         rb  = pick();
         exp = ref_model(op, ra, rb);
         issue(op, ra, rb, 1'b1, exp);
         gap = $urandom_range(33, 37);
         if ($urandom_range(0, 4) == 0) begin
            repeat (3) @(negedge clk);
            issue(5'd9 + 5'($urandom_range(0, 7)), $urandom, $urandom, 1'b0, 32'd0);
            gap = gap - 4;
         end
         repeat (gap) @(negedge clk);
      end
      drain();

      // Asynchronous reset mid-CALC
      issue(5'd9, 32'd3, 32'd3, 1'b1, 32'd9);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_busy",   {31'd0, busy_o}, 32'd0);
      chk("async_rst_done",   {31'd0, done_o}, 32'd0);
      chk("async_rst_result", result_o,        32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      issue(5'd16, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the RV32IM execute stage.
- Sits directly downstream of alu_decoder. It consumes the 5-bit alu_op code and executes the M-extension codes: mulu, mulhs, mulhsu, mulhu, divu, divs, remu, and rems.
- Single-cycle ALU codes are ignored here; they belong to the ALU.
- Uses a start/busy/done handshake with fixed latency, so the hazard unit can stall deterministically.

Parameters:
XLEN, 32, operand and result width
OP_W, 5, width of alu_op_i

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start_i  in  1  request; accepted only in IDLE or DONE
kill_i  in  1  pipeline flush; synchronous abort
alu_op_i  in  OP_W  op code from alu_decoder
a_i  in  XLEN  rs1 operand
b_i  in  XLEN  rs2 operand
busy_o  out  1  high in CALC and FIN
done_o  out  1  one-cycle pulse; result_o valid
result_o  out  XLEN  result; held until next accepted start

Behaviour:
- Op codes:
  - mulu 01001 (low 32 bits of a*b)
  - mulhs 01010 (high, signed x signed)
  - mulhsu 01011 (high, signed a x unsigned b)
  - mulhu 01100 (high, unsigned x unsigned)
  - divu 01101, divs 01110, remu 01111, rems 10000
  - Any other code with start_i: ignored, no state change, no done_o.
- Reset (rst=0, async): state=IDLE, busy_o=0, done_o=0, result_o=0, all internal registers 0.
  - Applies immediately, including mid-operation.
- States: IDLE, CALC, FIN, DONE.
  - IDLE/DONE + accepted start: latch op, a_i, b_i; go to CALC.
    - Operands are captured here; later changes on a_i/b_i have no effect.
  - CALC: 32 iterations, one per cycle, tracked by a 5-bit counter. Goes to FIN when the counter reaches 31.
  - FIN: sign correction and special-case override; result_o registered. Goes to DONE.
  - DONE: done_o=1 for exactly this cycle.
    - Start accepted here moves directly to CALC. Otherwise go to IDLE.
- Latency:
  - Start sampled at edge k. CALC spans cycles k+1..k+32, FIN is k+33, done_o is high in cycle k+34.
  - Latency is fixed for all ops and operand values.
- Arithmetic:
  - Signed operands are converted to magnitudes at accept.
    - a is signed for mulhs, mulhsu, divs, rems.
    - b is signed for mulhs, divs, rems.
  - Multiply: unsigned shift-add into a 64-bit accumulator. Negate the 64-bit product in FIN if the operand signs differ (signed operands only).
  - Divide: unsigned restoring division, 33-bit partial remainder.
    - Quotient is negated if signs differ.
    - Remainder takes the sign of the dividend.
- Special cases (FIN override, same latency):
  - b=0: divu/divs give 0xFFFFFFFF; remu/rems give a.
  - divs/rems with a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- start_i while busy_o=1: ignored.
- kill_i:
  - In CALC or FIN: go to IDLE next edge. No done_o; result_o keeps its previous value.
  - In IDLE/DONE with start_i: kill wins, start is ignored.
  - In DONE alone: done_o still pulses (the result was already produced); next state is IDLE.

Test Plan:
- mulu a=7, b=0xFFFFFFFD, start at cycle 0 -> done_o only in cycle 34, result 0xFFFFFFEB, busy_o high cycles 1-33.
- Multiply-high ops:
  - mulhs a=b=0x80000000 -> 0x40000000.
  - mulhu a=b=0xFFFFFFFF -> 0xFFFFFFFE.
  - mulhsu a=b=0xFFFFFFFF -> 0xFFFFFFFF.
- Signed/unsigned divide, a=0xFFFFFFF9, b=2:
  - divs -> 0xFFFFFFFD; rems -> 0xFFFFFFFF.
  - divu 7/2 -> 3; remu 7/2 -> 1.
- Special cases:
  - divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5.
  - divs 0x80000000/0xFFFFFFFF -> 0x80000000; rems -> 0.
- Abort and reset:
  - kill_i in cycle 10 of CALC -> busy_o=0 from cycle 11, no done_o, result_o unchanged; a new start in cycle 12 completes normally.
  - rst=0 mid-CALC -> busy_o, done_o, result_o are 0 asynchronously.
- Handshake:
  - start_i asserted in the DONE cycle -> accepted, second done_o 34 cycles later.
  - start_i with and_op 00000 -> ignored.
  - start_i while busy -> ignored, first result intact.
